saf_fir_error: RTL and testbench

// Sample-side partner of the per-tap weight updaters. Accepts x(n) and d(n), forms the FIR output
// y(n)=sum w_k*x(n-k) with one time-multiplexed MAC, computes e(n)=d(n)-y(n) and emits mu*e(n).

---
 rtl/saf_fir_error.sv | 127 ++++++++++++
 tb/tb_saf_fir_error.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/saf_fir_error.sv
// Sample-side LMS partner: time-multiplexed FIR MAC, error e=d-y and scaled error mu*e for tap updaters.
// Define SAF_FIR_SAT_EN to saturate y, e and mu_error instead of wrapping.
module saf_fir_error #(
    parameter int unsigned      WIDTH = 16,
    parameter int unsigned      QP    = 12,
    parameter int unsigned      TAPS  = 4,
    parameter logic [WIDTH-1:0] MU    = 16'h0400
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    x_valid,
    output logic                    x_ready,
    input  logic [WIDTH-1:0]        x_in,
    input  logic [WIDTH-1:0]        d_in,
    input  logic [TAPS*WIDTH-1:0]   w_flat,
    output logic [TAPS*WIDTH-1:0]   x_taps,
    output logic [WIDTH-1:0]        y_out,
    output logic [WIDTH-1:0]        e_out,
    output logic                    y_valid,
    output logic [WIDTH-1:0]        mu_error
);
    localparam int unsigned IW = $clog2(TAPS);
    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned AW = PW + IW;
    localparam logic signed [AW-1:0] RND  = AW'(1) <<< (QP - 1);
    localparam logic signed [AW-1:0] MU_A = AW'($signed(MU));
    localparam logic [IW-1:0]        LAST = IW'(TAPS - 1);

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_ERR, S_UPDATE} state_t;

    state_t                  state;
    logic [IW-1:0]           idx;
    logic signed [AW-1:0]    acc;
    logic signed [WIDTH-1:0] d_lat;

    logic signed [WIDTH-1:0] w_cur, x_cur;
    logic signed [PW-1:0]    prod;
    logic signed [WIDTH-1:0] y_c, e_c, m_c;

    // One MAC term per cycle, selected by idx
    always_comb begin
        w_cur = w_flat[int'(idx)*WIDTH +: WIDTH];
        x_cur = x_taps[int'(idx)*WIDTH +: WIDTH];
        prod  = w_cur * x_cur;
    end

`ifdef SAF_FIR_SAT_EN
    localparam logic signed [AW-1:0] SMAX = (AW'(1) <<< (WIDTH - 1)) - AW'(1);
    localparam logic signed [AW-1:0] SMIN = -SMAX - AW'(1);

    function automatic logic signed [WIDTH-1:0] sat(input logic signed [AW-1:0] v);
        if (v > SMAX)      sat = SMAX[WIDTH-1:0];
        else if (v < SMIN) sat = SMIN[WIDTH-1:0];
        else               sat = v[WIDTH-1:0];
    endfunction

    logic signed [AW-1:0] y_full, e_full, m_full;

    // Round, then clamp at each stage so e and mu*e see the clamped y
    always_comb begin
        y_full = (acc + RND) >>> QP;
        y_c    = sat(y_full);
        e_full = AW'(d_lat) - AW'(y_c);
        e_c    = sat(e_full);
        m_full = (AW'(e_c) * MU_A + RND) >>> QP;
        m_c    = sat(m_full);
    end
`else
    // Round-half-up then keep the low WIDTH bits (modulo wrap)
    always_comb begin
        y_c = WIDTH'((acc + RND) >>> QP);
        e_c = d_lat - y_c;
        m_c = WIDTH'((AW'(e_c) * MU_A + RND) >>> QP);
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            idx      <= '0;
            acc      <= '0;
            d_lat    <= '0;
            x_taps   <= '0;
            y_out    <= '0;
            e_out    <= '0;
            y_valid  <= 1'b0;
            mu_error <= '0;
            x_ready  <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (x_valid) begin
                        x_taps  <= {x_taps[(TAPS-1)*WIDTH-1:0], x_in};
                        d_lat   <= d_in;
                        acc     <= '0;
                        idx     <= '0;
                        x_ready <= 1'b0;
                        state   <= S_MAC;
                    end
                end
                S_MAC: begin
                    acc <= acc + AW'(prod);
                    idx <= idx + IW'(1);
                    if (idx == LAST) state <= S_ERR;
                end
                S_ERR: begin
                    y_out    <= y_c;
                    e_out    <= e_c;
                    mu_error <= m_c;
                    y_valid  <= 1'b1;
                    state    <= S_UPDATE;
                end
                S_UPDATE: begin
                    // Updaters commit on this edge; scaled error must drop back to 0
                    mu_error <= '0;
                    y_valid  <= 1'b0;
                    x_ready  <= 1'b1;
                    state    <= S_IDLE;
                end
                default: begin
                    state   <= S_IDLE;
                    x_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_saf_fir_error.sv
// Directed self-checking bench for saf_fir_error (WIDTH=16, QP=12, TAPS=4, MU=0x0400).
module tb_saf_fir_error;
    localparam int W = 16;
    localparam int T = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic           x_valid;
    logic           x_ready;
    logic [W-1:0]   x_in, d_in;
    logic [T*W-1:0] w_flat;
    logic [T*W-1:0] x_taps;
    logic [W-1:0]   y_out, e_out, mu_error;
    logic           y_valid;

    int checks = 0;
    int errors = 0;

    saf_fir_error #(.WIDTH(16), .QP(12), .TAPS(4), .MU(16'h0400)) dut (
        .clk(clk), .reset(reset), .x_valid(x_valid), .x_ready(x_ready),
        .x_in(x_in), .d_in(d_in), .w_flat(w_flat), .x_taps(x_taps),
        .y_out(y_out), .e_out(e_out), .y_valid(y_valid), .mu_error(mu_error)
    );

    always #5 clk = ~clk;

    // Feed one sample and check the full 7-cycle transaction
    task automatic do_sample(input string nm, input logic [W-1:0] x, input logic [W-1:0] d,
                             input logic [W-1:0] ey, input logic [W-1:0] ee, input logic [W-1:0] em);
        int n = 0;
        @(negedge clk);
        while (!x_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (x_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_timeout: x_ready=%b required 1", nm, x_ready);
        end
        x_valid = 1'b1; x_in = x; d_in = d;
        @(posedge clk);
        #1 x_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (y_valid !== 1'b0 || mu_error !== '0 || x_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s busy%0d: y_valid=%b mu_error=%h x_ready=%b required 0,0000,0",
                         nm, i, y_valid, mu_error, x_ready);
            end
        end
        @(negedge clk);
        checks++;
        if (y_valid !== 1'b1 || mu_error !== em || y_out !== ey || e_out !== ee) begin
            errors++;
            $display("FAIL %s update: y_valid=%b y=%h e=%h mu=%h required 1 y=%h e=%h mu=%h",
                     nm, y_valid, y_out, e_out, mu_error, ey, ee, em);
        end
        @(negedge clk);
        checks++;
        if (y_valid !== 1'b0 || mu_error !== '0 || x_ready !== 1'b1 || y_out !== ey || e_out !== ee) begin
            errors++;
            $display("FAIL %s after: y_valid=%b mu=%h x_ready=%b y=%h e=%h required 0 0000 1 y=%h e=%h",
                     nm, y_valid, mu_error, x_ready, y_out, e_out, ey, ee);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; x_valid = 1'b0; x_in = '0; d_in = '0; w_flat = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (y_out !== '0 || e_out !== '0 || y_valid !== 1'b0 || mu_error !== '0 ||
            x_taps !== '0 || x_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: y=%h e=%h v=%b mu=%h taps=%h rdy=%b required all 0, rdy=1",
                     y_out, e_out, y_valid, mu_error, x_taps, x_ready);
        end
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (mu_error !== '0 || y_valid !== 1'b0 || x_ready !== 1'b1) begin
                errors++;
                $display("FAIL reset_idle%0d: mu=%h v=%b rdy=%b required 0000 0 1",
                         i, mu_error, y_valid, x_ready);
            end
        end
    endtask

    task automatic test_impulse();
        w_flat = {16'h0000, 16'h0000, 16'h0800, 16'h1000};
        do_sample("imp0", 16'h1000, 16'h0000, 16'h1000, 16'hF000, 16'hFC00);
        checks++;
        if (x_taps !== 64'h0000_0000_0000_1000) begin
            errors++;
            $display("FAIL imp_taps: x_taps=%h required 0000000000001000", x_taps);
        end
        do_sample("imp1", 16'h0000, 16'h0000, 16'h0800, 16'hF800, 16'hFE00);
        do_sample("imp2", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        do_sample("imp3", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        checks++;
        if (x_taps !== 64'h1000_0000_0000_0000) begin
            errors++;
            $display("FAIL imp_taps_end: x_taps=%h required 1000000000000000", x_taps);
        end
    endtask

    task automatic test_error();
        w_flat = '0;
        do_sample("err", 16'h1000, 16'h0800, 16'h0000, 16'h0800, 16'h0200);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0]   vals [6] = '{16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0055, 16'h0066};
        logic [T*W-1:0] model = '0;
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        w_flat = {16'h0100, 16'h0200, 16'h0300, 16'h0400};
        x_valid = 1'b1; x_in = vals[0]; d_in = 16'h0000;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (x_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready%0d: x_ready=%b required 1", i, x_ready);
            end
            @(posedge clk);
            model = {model[(T-1)*W-1:0], vals[i]};
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                checks++;
                if (x_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_busy%0d_%0d: x_ready=%b required 0", i, c, x_ready);
                end
                if (c == 0) begin
                    checks++;
                    if (x_taps !== model) begin
                        errors++;
                        $display("FAIL b2b_taps%0d: x_taps=%h required %h", i, x_taps, model);
                    end
                end
                if (c == 2) x_in = 16'hDEAD;
                if (c == 5) x_in = (i < 5) ? vals[i+1] : 16'h0000;
            end
            @(negedge clk);
        end
        x_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (x_taps !== model || x_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_final: x_taps=%h rdy=%b required %h 1", x_taps, x_ready, model);
        end
    endtask

    task automatic test_wrap();
        w_flat = {16'h0000, 16'h0000, 16'h0000, 16'h7FFF};
`ifdef SAF_FIR_SAT_EN
        do_sample("sat", 16'h7FFF, 16'h0000, 16'h7FFF, 16'h8001, 16'hE000);
`else
        do_sample("wrap", 16'h7FFF, 16'h0000, 16'hFFF0, 16'h0010, 16'h0004);
`endif
    endtask

    task automatic test_reset_mid();
        w_flat = {16'h1000, 16'h1000, 16'h1000, 16'h1000};
        @(negedge clk);
        x_valid = 1'b1; x_in = 16'h1234; d_in = 16'h0100;
        @(posedge clk);
        #1 x_valid = 1'b0;
        @(negedge clk);
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        checks++;
        if (x_taps !== '0 || x_ready !== 1'b1 || y_valid !== 1'b0 || mu_error !== '0 ||
            y_out !== '0 || e_out !== '0) begin
            errors++;
            $display("FAIL mid_reset: taps=%h rdy=%b v=%b mu=%h y=%h e=%h required 0 1 0 0 0 0",
                     x_taps, x_ready, y_valid, mu_error, y_out, e_out);
        end
        x_valid = 1'b1; x_in = 16'h5555;
        @(negedge clk);
        reset = 1'b0; x_valid = 1'b0;
        checks++;
        if (x_taps !== '0 || x_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_wins: taps=%h rdy=%b required 0 1", x_taps, x_ready);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (y_valid !== 1'b0 || mu_error !== '0 || x_ready !== 1'b1) begin
                errors++;
                $display("FAIL mid_quiet%0d: v=%b mu=%h rdy=%b required 0 0000 1",
                         i, y_valid, mu_error, x_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_error();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
